sequenciador_resposta_tx: RTL and testbench



---
 rtl/pkg_uart_resposta.sv | 21 ++
 rtl/sequenciador_resposta_tx_if.sv | 25 ++
 rtl/detector_borda_subida.sv | 21 ++
 rtl/sequenciador_resposta_tx.sv | 125 ++++++++++++
 tb/tb_sequenciador_resposta_tx.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkg_uart_resposta.sv
// rtl/pkg_uart_resposta.sv - states, sizes and defaults of the UART response sequencer
package pkg_uart_resposta;

  localparam int NUM_BYTES_RESPOSTA     = 2;
  localparam int CICLOS_TIMEOUT_PADRAO  = 65535;
  localparam int LARGURA_TIMEOUT_PADRAO = 16;

  typedef enum logic [2:0] {
    ESPERA      = 3'd0,
    CARREGA     = 3'd1,
    AGUARDA_FIM = 3'd2,
    INTERVALO   = 3'd3,
    FIM         = 3'd4,
    ERRO        = 3'd5
  } estado_t;

  function automatic logic ultimo_byte(input logic indice);
    return indice == 1'(NUM_BYTES_RESPOSTA - 1);
  endfunction

endpackage

// File: rtl/sequenciador_resposta_tx_if.sv
// rtl/sequenciador_resposta_tx_if.sv - request side and transmitter side of the response sequencer
interface sequenciador_resposta_tx_if;

  logic       enviarResposta;
  logic [7:0] byteComando;
  logic [7:0] byteDado;
  logic       ocupado;
  logic       respostaEnviada;
  logic       erroTimeout;
  logic       haDadosParaTransmitir;
  logic [7:0] byteASerTransmitido;
  logic       indicaTransmissao;
  logic       bitsEstaoEnviados;

  modport master (
    input  enviarResposta, byteComando, byteDado, indicaTransmissao, bitsEstaoEnviados,
    output ocupado, respostaEnviada, erroTimeout, haDadosParaTransmitir, byteASerTransmitido
  );

  modport slave (
    output enviarResposta, byteComando, byteDado, indicaTransmissao, bitsEstaoEnviados,
    input  ocupado, respostaEnviada, erroTimeout, haDadosParaTransmitir, byteASerTransmitido
  );

endinterface

// File: rtl/detector_borda_subida.sv
// rtl/detector_borda_subida.sv - one-cycle pulse on the rising edge of a level input
module detector_borda_subida (
  input  logic clock,
  input  logic reset,
  input  logic i_sinal,
  output logic o_pulso
);

  logic r_anterior;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_anterior <= 1'b0;
    end else begin
      r_anterior <= i_sinal;
    end
  end

  assign o_pulso = i_sinal & ~r_anterior;

endmodule

// File: rtl/sequenciador_resposta_tx.sv
// rtl/sequenciador_resposta_tx.sv - feeds a 2-byte response to the UART transmitter one byte at a time
module sequenciador_resposta_tx
  import pkg_uart_resposta::*;
#(
  parameter int CICLOS_TIMEOUT  = CICLOS_TIMEOUT_PADRAO,
  parameter int LARGURA_TIMEOUT = LARGURA_TIMEOUT_PADRAO
) (
  input logic                        clock,
  input logic                        reset,
  sequenciador_resposta_tx_if.master bus
);

  localparam logic [LARGURA_TIMEOUT-1:0] LIMITE = LARGURA_TIMEOUT'(CICLOS_TIMEOUT - 1);
  localparam logic [LARGURA_TIMEOUT-1:0] MAXIMO = '1;

  estado_t                    r_estado;
  estado_t                    w_prox_estado;
  logic [7:0]                 r_byte_dado;
  logic [7:0]                 r_byte_tx;
  logic                       r_indice;
  logic [LARGURA_TIMEOUT-1:0] r_contador;
  logic [LARGURA_TIMEOUT-1:0] w_contador_inc;
  logic                       w_borda_done;
  logic                       w_tx_livre;
  logic                       w_expirou;
  logic                       w_carrega_cmd;
  logic                       w_carrega_dado;
  logic                       w_limpa_cont;
  logic                       w_conta;

  detector_borda_subida u_borda_done (
    .clock   (clock),
    .reset   (reset),
    .i_sinal (bus.bitsEstaoEnviados),
    .o_pulso (w_borda_done)
  );

  // The transmitter ignores valid during its done/cleanup cycles, so both must be low.
  assign w_tx_livre     = ~bus.indicaTransmissao & ~bus.bitsEstaoEnviados;
  assign w_contador_inc = r_contador + 1'b1;
  assign w_expirou      = (w_contador_inc == LIMITE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= ESPERA;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  always_comb begin
    w_prox_estado  = r_estado;
    w_carrega_cmd  = 1'b0;
    w_carrega_dado = 1'b0;
    w_limpa_cont   = 1'b0;
    w_conta        = 1'b0;
    unique case (r_estado)
      ESPERA: begin
        if (bus.enviarResposta && w_tx_livre) begin
          w_carrega_cmd = 1'b1;
          w_prox_estado = CARREGA;
        end
      end
      CARREGA: begin
        w_limpa_cont  = 1'b1;
        w_prox_estado = AGUARDA_FIM;
      end
      AGUARDA_FIM: begin
        w_conta = 1'b1;
        if (w_borda_done) begin
          w_prox_estado = INTERVALO;
        end else if (w_expirou) begin
          w_prox_estado = ERRO;
        end
      end
      INTERVALO: begin
        w_conta = 1'b1;
        if (w_tx_livre) begin
          if (ultimo_byte(r_indice)) begin
            w_prox_estado = FIM;
          end else begin
            w_carrega_dado = 1'b1;
            w_prox_estado  = CARREGA;
          end
        end else if (w_expirou) begin
          w_prox_estado = ERRO;
        end
      end
      FIM:     w_prox_estado = ESPERA;
      ERRO:    w_prox_estado = ESPERA;
      default: w_prox_estado = ESPERA;
    endcase
  end

  // The command byte goes straight into the output register; only the data byte needs holding.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_byte_dado <= 8'h00;
      r_byte_tx   <= 8'h00;
      r_indice    <= 1'b0;
      r_contador  <= '0;
    end else begin
      if (w_carrega_cmd) begin
        r_byte_tx   <= bus.byteComando;
        r_byte_dado <= bus.byteDado;
        r_indice    <= 1'b0;
      end else if (w_carrega_dado) begin
        r_byte_tx <= r_byte_dado;
        r_indice  <= 1'b1;
      end
      if (w_limpa_cont) begin
        r_contador <= '0;
      end else if (w_conta && (r_contador != MAXIMO)) begin
        r_contador <= w_contador_inc;
      end
    end
  end

  assign bus.ocupado               = (r_estado != ESPERA);
  assign bus.respostaEnviada       = (r_estado == FIM);
  assign bus.erroTimeout           = (r_estado == ERRO);
  assign bus.haDadosParaTransmitir = (r_estado == CARREGA);
  assign bus.byteASerTransmitido   = r_byte_tx;

endmodule

// File: tb/tb_sequenciador_resposta_tx.sv
// tb/tb_sequenciador_resposta_tx.sv - bench for the response sequencer with a behavioural UART transmitter
`timescale 1ns/1ps
module tb_sequenciador_resposta_tx;

  localparam int CPB = 4;
  localparam int TO  = 100;
  localparam int PERIODO_BYTE = 10 * CPB + 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sequenciador_resposta_tx_if bus ();

  sequenciador_resposta_tx #(.CICLOS_TIMEOUT(TO), .LARGURA_TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Transmitter model: 10-bit frame of CPB cycles per bit, then done for 2 cycles; never reset.
  int         tx_fase   = 0;
  int         tx_cnt    = 0;
  bit         tx_mudo   = 1'b0;
  logic [9:0] tx_quadro = '1;
  logic       tx_busy   = 1'b0;
  logic       tx_done   = 1'b0;
  logic       tx_linha  = 1'b1;

  assign bus.indicaTransmissao = tx_busy;
  assign bus.bitsEstaoEnviados = tx_done;

  always @(posedge clock) begin
    case (tx_fase)
      0: if (bus.haDadosParaTransmitir && !tx_mudo) begin
        tx_quadro <= {1'b1, bus.byteASerTransmitido, 1'b0};
        tx_fase   <= 1;
        tx_cnt    <= 0;
        tx_busy   <= 1'b1;
        tx_linha  <= 1'b0;
      end
      1: if (tx_cnt == 10 * CPB - 1) begin
        tx_fase  <= 2;
        tx_cnt   <= 0;
        tx_busy  <= 1'b0;
        tx_done  <= 1'b1;
        tx_linha <= 1'b1;
      end else begin
        tx_cnt   <= tx_cnt + 1;
        tx_linha <= tx_quadro[(tx_cnt + 1) / CPB];
      end
      default: if (tx_cnt == 1) begin
        tx_done <= 1'b0;
        tx_fase <= 0;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    endcase
  end

  // Serial line decoder, sampling mid-bit.
  logic [7:0] rx_q[$];
  int         rx_erro_stop = 0;
  always begin
    @(negedge clock);
    if (tx_linha === 1'b0) begin
      logic [7:0] b;
      repeat (CPB / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clock);
        b[i] = tx_linha;
      end
      repeat (CPB) @(negedge clock);
      if (tx_linha !== 1'b1) rx_erro_stop++;
      rx_q.push_back(b);
    end
  end

  int   vld_cnt = 0, resp_cnt = 0, err_cnt = 0, guarda_viol = 0, dupla_viol = 0;
  logic vld_ant = 1'b0;
  always @(negedge clock) begin
    if (bus.haDadosParaTransmitir === 1'b1) begin
      vld_cnt++;
      if (tx_busy || tx_done) guarda_viol++;
      if (vld_ant) dupla_viol++;
    end
    vld_ant = bus.haDadosParaTransmitir;
    if (bus.respostaEnviada === 1'b1) resp_cnt++;
    if (bus.erroTimeout === 1'b1) err_cnt++;
  end

  task automatic pulso_req(input logic [7:0] c, input logic [7:0] d);
    bus.enviarResposta = 1'b1;
    bus.byteComando    = c;
    bus.byteDado       = d;
    @(negedge clock);
    bus.enviarResposta = 1'b0;
    bus.byteComando    = 8'($urandom);
    bus.byteDado       = 8'($urandom);
  endtask

  task automatic espera_resposta(output int ciclos);
    ciclos = 0;
    while (bus.respostaEnviada !== 1'b1 && ciclos < 400) begin
      @(negedge clock);
      ciclos++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_assert++;
    if ({bus.ocupado, bus.respostaEnviada, bus.erroTimeout, bus.haDadosParaTransmitir} !== 4'b0000 ||
        bus.byteASerTransmitido !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got ocup/resp/err/vld=%b%b%b%b byte=%h, required 0000 byte=00",
               bus.ocupado, bus.respostaEnviada, bus.erroTimeout, bus.haDadosParaTransmitir,
               bus.byteASerTransmitido);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_nominal();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] c, d;
      int ciclos, n_v;
      bit ocup_ok, byte2_ok;
      c = (k == 0) ? 8'hA5 : 8'($urandom);
      d = (k == 0) ? 8'h1C : 8'($urandom);
      rx_q.delete();
      pulso_req(c, d);
      n_assert++;
      if (bus.haDadosParaTransmitir !== 1'b1 || bus.byteASerTransmitido !== c || bus.ocupado !== 1'b1) begin
        n_fail++;
        $display("FAIL nominal_first_valid: got vld=%b byte=%h ocup=%b, required 1 %h 1",
                 bus.haDadosParaTransmitir, bus.byteASerTransmitido, bus.ocupado, c);
      end
      n_v = 1; ocup_ok = 1'b1; byte2_ok = 1'b1; ciclos = 0;
      do begin
        @(negedge clock);
        ciclos++;
        if (bus.ocupado !== 1'b1) ocup_ok = 1'b0;
        if (bus.haDadosParaTransmitir === 1'b1) begin
          n_v++;
          if (bus.byteASerTransmitido !== d) byte2_ok = 1'b0;
        end
      end while (bus.respostaEnviada !== 1'b1 && ciclos < 400);
      n_assert++;
      if (ciclos != 2 * PERIODO_BYTE || n_v != 2 || !ocup_ok || !byte2_ok) begin
        n_fail++;
        $display("FAIL nominal_frame: got latency=%0d valids=%0d ocup_ok=%0d byte2_ok=%0d, required %0d 2 1 1",
                 ciclos, n_v, ocup_ok, byte2_ok, 2 * PERIODO_BYTE);
      end
      n_assert++;
      if (rx_q.size() != 2 || rx_q[0] !== c || rx_q[1] !== d) begin
        n_fail++;
        $display("FAIL nominal_serial: got %0d bytes, required %h %h", rx_q.size(), c, d);
      end
      @(negedge clock);
      n_assert++;
      if (bus.respostaEnviada !== 1'b0 || bus.ocupado !== 1'b0) begin
        n_fail++;
        $display("FAIL nominal_end: got resp=%b ocup=%b, required 0 0", bus.respostaEnviada, bus.ocupado);
      end
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic test_busy_drop();
    int v0, r0, ciclos;
    rx_q.delete();
    v0 = vld_cnt; r0 = resp_cnt;
    pulso_req(8'hA5, 8'h1C);
    repeat (9) @(negedge clock);
    pulso_req(8'hFF, 8'hFF);
    espera_resposta(ciclos);
    repeat (100) @(negedge clock);
    n_assert++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h1C) begin
      n_fail++;
      $display("FAIL busy_drop_serial: got %0d bytes, required a5 1c", rx_q.size());
    end
    n_assert++;
    if (resp_cnt - r0 != 1 || vld_cnt - v0 != 2) begin
      n_fail++;
      $display("FAIL busy_drop_counts: got resp=%0d valids=%0d, required 1 2", resp_cnt - r0, vld_cnt - v0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c, d;
    int v0, ciclos;
    c = 8'($urandom); d = 8'($urandom);
    rx_q.delete();
    v0 = vld_cnt;
    pulso_req(c, d);
    espera_resposta(ciclos);
    @(negedge clock);
    pulso_req(8'h01, 8'h80);
    n_assert++;
    if (bus.haDadosParaTransmitir !== 1'b1 || bus.byteASerTransmitido !== 8'h01) begin
      n_fail++;
      $display("FAIL b2b_accept: got vld=%b byte=%h, required 1 01", bus.haDadosParaTransmitir, bus.byteASerTransmitido);
    end
    espera_resposta(ciclos);
    repeat (5) @(negedge clock);
    n_assert++;
    if (rx_q.size() != 4 || rx_q[0] !== c || rx_q[1] !== d || rx_q[2] !== 8'h01 || rx_q[3] !== 8'h80 ||
        vld_cnt - v0 != 4) begin
      n_fail++;
      $display("FAIL b2b_serial: got %0d bytes valids=%0d, required %h %h 01 80 and 4 valids",
               rx_q.size(), vld_cnt - v0, c, d);
    end
  endtask

  task automatic test_timeout();
    int r0, e0, ciclos;
    tx_mudo = 1'b1;
    r0 = resp_cnt; e0 = err_cnt;
    pulso_req(8'($urandom), 8'($urandom));
    ciclos = 0;
    do begin
      @(negedge clock);
      ciclos++;
    end while (bus.erroTimeout !== 1'b1 && ciclos < 300);
    n_assert++;
    if (ciclos != TO) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles after valid, required %0d", ciclos, TO);
    end
    @(negedge clock);
    n_assert++;
    if (bus.ocupado !== 1'b0 || bus.erroTimeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_end: got ocup=%b err=%b, required 0 0", bus.ocupado, bus.erroTimeout);
    end
    repeat (5) @(negedge clock);
    n_assert++;
    if (resp_cnt != r0 || err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL timeout_counts: got resp=%0d err=%0d, required 0 1", resp_cnt - r0, err_cnt - e0);
    end
    tx_mudo = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ciclos;
    rx_q.delete();
    pulso_req(8'hA5, 8'h1C);
    repeat (18) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_assert++;
    if ({bus.ocupado, bus.respostaEnviada, bus.erroTimeout, bus.haDadosParaTransmitir} !== 4'b0000 ||
        bus.byteASerTransmitido !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got ocup/resp/err/vld=%b%b%b%b byte=%h, required 0000 00",
               bus.ocupado, bus.respostaEnviada, bus.erroTimeout, bus.haDadosParaTransmitir,
               bus.byteASerTransmitido);
    end
    pulso_req(8'h3C, 8'hC3);
    n_assert++;
    if (bus.ocupado !== 1'b0 || bus.haDadosParaTransmitir !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_guard: got ocup=%b vld=%b, required 0 0", bus.ocupado, bus.haDadosParaTransmitir);
    end
    ciclos = 0;
    while (tx_fase != 0 && ciclos < 200) begin
      @(negedge clock);
      ciclos++;
    end
    @(negedge clock);
    pulso_req(8'h5A, 8'h96);
    espera_resposta(ciclos);
    n_assert++;
    if (ciclos >= 400 || rx_q.size() != 3 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h5A || rx_q[2] !== 8'h96) begin
      n_fail++;
      $display("FAIL reset_mid_serial: got %0d bytes wait=%0d, required a5 5a 96", rx_q.size(), ciclos);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_done_guard();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] c, d;
      int v0, ciclos;
      c = 8'($urandom); d = 8'($urandom);
      rx_q.delete();
      v0 = vld_cnt;
      pulso_req(c, d);
      espera_resposta(ciclos);
      repeat (2) @(negedge clock);
      n_assert++;
      if (vld_cnt - v0 != 2 || rx_q.size() != 2 || rx_q[0] !== c || rx_q[1] !== d) begin
        n_fail++;
        $display("FAIL done_guard_frame: got valids=%0d bytes=%0d, required 2 valids and %h %h",
                 vld_cnt - v0, rx_q.size(), c, d);
      end
    end
    n_assert++;
    if (guarda_viol != 0 || dupla_viol != 0 || rx_erro_stop != 0) begin
      n_fail++;
      $display("FAIL done_guard_rules: got early=%0d double=%0d badstop=%0d, required 0 0 0",
               guarda_viol, dupla_viol, rx_erro_stop);
    end
  endtask

  initial begin
    bus.enviarResposta = 1'b0;
    bus.byteComando    = 8'h00;
    bus.byteDado       = 8'h00;
    test_reset();
    test_nominal();
    test_busy_drop();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_done_guard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
